// File: rtl/conv_window_filter.sv
// Streaming KxK window filter (passthrough / Sobel magnitude / binomial blur) on a raster pixel stream.
// Latency: two edges from the accepting edge to the outputs; input bubbles are reproduced one-for-one.
// Backpressure: none. Every accepted pixel yields exactly one out_valid that downstream must take.
// Ports: clk/rst (async, active-high); in_valid/in_sof/in_pixel/mode input stream (mode latched on SOF);
//        out_valid/out_sof/out_eof/out_pixel filtered stream with frame markers.
module conv_window_filter #(
  parameter int PIX_W = 4,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int K     = 5,
  parameter int SHIFT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic [1:0]       mode,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eof,
  output logic [PIX_W-1:0] out_pixel
);

  localparam int H   = K / 2;
  localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int GW  = PIX_W + 7;
  localparam int BW  = PIX_W + 8;
  localparam int BSH = (K == 3) ? 4 : 8;
  localparam logic [PIX_W-1:0] PMAX = '1;

  generate
    if (K != 3 && K != 5) begin : g_bad_k
      $error("conv_window_filter: K must be 3 or 5");
    end
  endgenerate

  // Smoothing vector S
  function automatic int f_s(input int idx);
    int v;
    if (K == 3) v = (idx == 1) ? 2 : 1;
    else begin
      case (idx)
        0, 4:    v = 1;
        1, 3:    v = 4;
        default: v = 6;
      endcase
    end
    return v;
  endfunction

  // Derivative vector D
  function automatic int f_d(input int idx);
    int v;
    if (K == 3) v = idx - 1;
    else begin
      case (idx)
        0:       v = -1;
        1:       v = -2;
        3:       v = 2;
        4:       v = 1;
        default: v = 0;
      endcase
    end
    return v;
  endfunction

  logic [CW-1:0]    r_col, w_col, w_col_nxt;
  logic [RW-1:0]    r_row, w_row, w_row_nxt;
  logic             w_last_col, w_last_row;
  logic [1:0]       r_mode;
  logic             r_s1_valid, r_s1_sof, r_s1_eof, r_s1_mask;
  logic [PIX_W-1:0] r_lb  [K-1][IMG_W];
  logic [PIX_W-1:0] r_win [K][K];
  logic [PIX_W-1:0] w_colv [K];

  // An accepted SOF restarts the raster at (0,0) regardless of the counters.
  assign w_col      = in_sof ? '0 : r_col;
  assign w_row      = in_sof ? '0 : r_row;
  assign w_last_col = (w_col == CW'(IMG_W - 1));
  assign w_last_row = (w_row == RW'(IMG_H - 1));
  assign w_col_nxt  = w_last_col ? '0 : w_col + 1'b1;
  assign w_row_nxt  = w_last_col ? (w_last_row ? '0 : w_row + 1'b1) : w_row;

  // New window column: bottom tap is the incoming pixel, the taps above come
  // from the line buffers (lb[0] = previous line, lb[1] = the one before, ...).
  always_comb begin
    w_colv[K-1] = in_pixel;
    for (int j = 0; j < K - 1; j++) w_colv[K-2-j] = r_lb[j][w_col];
  end

  // Line buffers: no reset so they map onto RAM; stale lines are hidden by the mask.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_lb[0][w_col] <= in_pixel;
      for (int j = 1; j < K - 1; j++) r_lb[j][w_col] <= r_lb[j-1][w_col];
    end
  end

  // Window shift rows; column K-1 holds the newest pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) r_win[i][j] <= '0;
    end else if (in_valid) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) r_win[i][j] <= r_win[i][j+1];
        r_win[i][K-1] <= w_colv[i];
      end
    end
  end

  // Stage 1: raster counters, mode latch and per-pixel flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col      <= '0;
      r_row      <= '0;
      r_mode     <= 2'd0;
      r_s1_valid <= 1'b0;
      r_s1_sof   <= 1'b0;
      r_s1_eof   <= 1'b0;
      r_s1_mask  <= 1'b0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_col     <= w_col_nxt;
        r_row     <= w_row_nxt;
        r_s1_sof  <= in_sof;
        r_s1_eof  <= w_last_col && w_last_row;
        // Window not yet fully inside the current frame/line.
        r_s1_mask <= (w_row < RW'(K - 1)) || (w_col < CW'(K - 1));
        if (in_sof) r_mode <= mode;
      end
    end
  end

  logic signed [GW-1:0] w_gx, w_gy;
  logic [GW-1:0]        w_ax, w_ay, w_mag, w_shf;
  logic [BW-1:0]        w_bsum, w_bshf;
  logic [PIX_W-1:0]     w_res;

  always_comb begin
    w_gx   = '0;
    w_gy   = '0;
    w_bsum = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        w_gx   = w_gx + GW'(f_s(i) * f_d(j)) * $signed(GW'(r_win[i][j]));
        w_gy   = w_gy + GW'(f_d(i) * f_s(j)) * $signed(GW'(r_win[i][j]));
        w_bsum = w_bsum + BW'(f_s(i) * f_s(j)) * BW'(r_win[i][j]);
      end
    end
  end

  assign w_ax   = w_gx[GW-1] ? -w_gx : w_gx;
  assign w_ay   = w_gy[GW-1] ? -w_gy : w_gy;
  assign w_mag  = w_ax + w_ay;
  assign w_shf  = w_mag >> SHIFT;
  assign w_bshf = w_bsum >> BSH;

  always_comb begin
    w_res = '0;
    if (!r_s1_mask) begin
      case (r_mode)
        2'd0:    w_res = r_win[H][H];
        2'd1:    w_res = (w_shf > GW'(PMAX)) ? PMAX : w_shf[PIX_W-1:0];
        2'd2:    w_res = (w_bshf > BW'(PMAX)) ? PMAX : w_bshf[PIX_W-1:0];
        default: w_res = '0;
      endcase
    end
  end

  // Stage 2: output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_pixel <= '0;
    end else begin
      out_valid <= r_s1_valid;
      out_sof   <= r_s1_valid && r_s1_sof;
      out_eof   <= r_s1_valid && r_s1_eof;
      out_pixel <= r_s1_valid ? w_res : '0;
    end
  end

endmodule

// File: doc/conv_window_filter.md
# conv_window_filter

Parametrised successor to the fixed 5×5 edge filter: a streaming K×K window engine with selectable operation (passthrough, Sobel magnitude, binomial blur), configurable pixel width, and explicit frame/border handling. It sits in the video path between the grayscale converter and the frame writer. It consumes one pixel per valid cycle and produces exactly one output pixel per accepted input, with fixed latency and frame markers carried alongside the data.

## Interface
Parameters:
- PIX_W, 4: pixel width in bits, for both input and output.
- IMG_W, 640: active pixels per line.
- IMG_H, 480: active lines per frame.
- K, 5: window size; only 3 or 5 are legal, and any other value is an elaboration error.
- SHIFT, 4: right shift applied to the Sobel magnitude before saturation.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-high.
- in_valid, input, 1: in_pixel is accepted this cycle.
- in_sof, input, 1: the accepted pixel is row 0, column 0 of a new frame.
- in_pixel, input, PIX_W: grayscale input pixel.
- mode, input, 2: 0 passthrough, 1 Sobel, 2 blur, 3 reserved (outputs 0). Latched only at SOF.
- out_valid, output, 1: out_pixel is valid this cycle.
- out_sof, output, 1: first output pixel of the frame.
- out_eof, output, 1: last output pixel of the frame.
- out_pixel, output, PIX_W: filtered pixel.

## Operation
- Buffering:
  - K-1 line buffers of IMG_W×PIX_W and K shift rows of K taps, as in the existing filter.
  - Line-buffer contents are not reset; this allows RAM inference. Stale data is hidden by the border mask.
- Counters:
  - col wraps IMG_W-1→0, and row increments on that wrap.
  - At (IMG_H-1, IMG_W-1), row also wraps to 0.
  - An accepted in_sof forces the current pixel to (0,0), even mid-frame (resync).
- Mode register:
  - Loads on accepted in_sof; reset value 0.
  - Changes to mode mid-frame are ignored.
- Window anchoring:
  - The newest pixel (row r, col c) is the window's bottom-right tap; H = K/2.
  - The output for stream position (r,c) is the filter centred at (r-H, c-H).
- Border mask: if r < K-1 or c < K-1, the output is 0 in every mode. This also suppresses row-wrap contamination in the shift rows.
- Passthrough: centre tap.
- Sobel:
  - Separable kernels: smoothing vector S (K=3: 1 2 1; K=5: 1 4 6 4 1) and derivative vector D (K=3: -1 0 1; K=5: -1 -2 0 2 1).
  - gx = Sᵀ·D (horizontal derivative); gy = its transpose.
  - mag = |gx| + |gy| (true absolute values, not the signed sum).
  - out = min(mag >> SHIFT, 2^PIX_W-1).
- Blur:
  - Kernel S⊗S; the sum is shifted right by 4 (K=3) or 8 (K=5), which is exact.
  - The result never exceeds 2^PIX_W-1.
- Arithmetic widths:
  - gx and gy are signed PIX_W+7 bits; mag is unsigned PIX_W+7 bits. No overflow is possible, since max |gx| = 48·(2^PIX_W-1).
- No back-pressure: the downstream block must accept every out_valid.

## Timing
- Stage 1 (edge E, when in_valid=1): update line buffers and shift rows, and register s1_valid, s1_sof, s1_eof and the masked flag. When in_valid=0, the window and counters hold and s1_valid is 0.
- Stage 2 (edge E+1, every cycle): register out_pixel, out_valid = s1_valid, out_sof and out_eof.
- Latency: the input accepted at edge E appears at the outputs after edge E+1. Bubbles are preserved one-for-one.
- out_sof is asserted with the output of the pixel accepted with in_sof.
- out_eof is asserted with the output of input (IMG_H-1, IMG_W-1).
- Reset clears all outputs, counters, shift rows and pipeline flags to 0 immediately.
- After rst deasserts, the first accepted pixel is treated as (0,0) even without in_sof.
- Reset mid-frame: out_valid=0 from assertion; the next frame starts with the border mask active.

## Test plan
Bench parameters: PIX_W=4, IMG_W=8, IMG_H=6, K=3, SHIFT=0 unless stated otherwise.
- Reset: hold rst with in_valid=1 → out_valid, out_sof, out_eof and out_pixel are all 0 throughout. First valid after release → out_valid=1 two edges later.
- Passthrough ramp:
  - Stimulus: mode=0, pixel n = n mod 16, in_sof on n=0.
  - Output at position n equals input n-9 when row≥2 and col≥2, and 0 otherwise.
  - out_sof is with output 0; out_eof is with output 47.
- Constant frame: all pixels 9 → Sobel interior 0; blur interior 9; borders 0.
- Vertical step:
  - Stimulus: cols 0–3 = 0, cols 4–7 = 15, Sobel mode.
  - Stream cols 4 and 5 → |gx| = 60, saturated to 15. Col 6 → 0.
  - Rerun with SHIFT=3 → cols 4 and 5 output 7.
- Bubbles: in_valid pattern 1,0,1,1,0 on the ramp → out_valid shows the same pattern delayed 2 edges, with data identical to the gap-free run.
- Resync and mode:
  - Assert in_sof at pixel 13 with mode=1 → rows 0–1 of the new frame output 0. mode is now Sobel.
  - Change mode to 2 mid-frame → no effect until the next in_sof.
  - Assert rst mid-frame → outputs are 0 immediately.
